// File: rtl/board_pkg.sv
// board_pkg: constants and types shared by the board link transmitter and receiver.
`default_nettype none

package board_pkg;

  localparam int         FRAME_BITS        = 162;
  localparam int         NUM_CELLS         = 81;
  localparam int         NUM_PAYLOAD_BYTES = 21;
  localparam logic [7:0] SYNC_BYTE         = 8'hA5;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_BLACK = 2'd1,
    CELL_WHITE = 2'd2
  } cell_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serializer; done pulses in the last stop-bit cycle so a
// start issued in that same cycle chains the next byte with no idle gap.
`default_nettype none

module uart_byte_tx
  import board_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       start,
  output logic       done,
  output logic       tx
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          tx_nx;
  logic          bit_end;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      tx      <= tx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    tx_nx      = tx;
    done       = 1'b0;
    if (state != TX_IDLE) begin
      cnt_nx = bit_end ? '0 : cnt + 1'b1;
    end
    case (state)
      TX_IDLE: begin
        if (start) begin
          state_nx = TX_START;
          shreg_nx = data;
          cnt_nx   = '0;
          tx_nx    = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_nx   = TX_DATA;
          bit_idx_nx = 3'd0;
          tx_nx      = shreg[0];
          shreg_nx   = {1'b0, shreg[7:1]};
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx = TX_STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = shreg[0];
            shreg_nx   = {1'b0, shreg[7:1]};
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          done = 1'b1;
          if (start) begin
            state_nx = TX_START;
            shreg_nx = data;
            tx_nx    = 1'b0;
          end else begin
            state_nx = TX_IDLE;
          end
        end
      end
      default: state_nx = TX_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/board_tx.sv
// board_tx: sends one 162-bit board frame as sync byte A5 plus 21 UART payload bytes.
// Optional trailing XOR checksum byte when BOARD_TX_CHECKSUM_EN is defined.
`default_nettype none

module board_tx
  import board_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [FRAME_BITS-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  tx_out,
  output logic                  busy_out
);

`ifdef BOARD_TX_CHECKSUM_EN
  localparam logic [4:0] TOTAL_BYTES = 5'(NUM_PAYLOAD_BYTES + 2);
`else
  localparam logic [4:0] TOTAL_BYTES = 5'(NUM_PAYLOAD_BYTES + 1);
`endif
  localparam int PAD_BITS = 8 * NUM_PAYLOAD_BYTES;

  logic [FRAME_BITS-1:0] frame;
  logic [4:0]            byte_cnt;
  logic [4:0]            idx;
  logic [PAD_BITS-1:0]   padded;
  logic [7:0]            payload;
  logic [7:0]            next_byte;
  logic                  accept;
  logic                  more;
  logic                  start;
  logic                  done;

  assign accept  = valid_in & ready_out;
  assign more    = (byte_cnt < TOTAL_BYTES);
  // byte_cnt counts bytes already handed to the serializer (sync included).
  assign idx     = byte_cnt - 5'd1;
  assign padded  = {{(PAD_BITS - FRAME_BITS){1'b0}}, frame};
  assign payload = padded[{idx, 3'b000} +: 8];

`ifdef BOARD_TX_CHECKSUM_EN
  logic [7:0] csum;
  logic       is_csum;

  assign is_csum = (idx == 5'(NUM_PAYLOAD_BYTES));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (done && more && !is_csum) begin
      csum <= csum ^ payload;
    end
  end
`endif

  always_comb begin
    start     = 1'b0;
    next_byte = SYNC_BYTE;
    if (accept) begin
      start = 1'b1;
    end else if (done && more) begin
      start     = 1'b1;
      next_byte = payload;
`ifdef BOARD_TX_CHECKSUM_EN
      if (is_csum) begin
        next_byte = csum;
      end
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame     <= '0;
      byte_cnt  <= '0;
      ready_out <= 1'b1;
      busy_out  <= 1'b0;
    end else if (accept) begin
      frame     <= data_in;
      byte_cnt  <= 5'd1;
      ready_out <= 1'b0;
      busy_out  <= 1'b1;
    end else if (done) begin
      if (more) begin
        byte_cnt <= byte_cnt + 5'd1;
      end else begin
        byte_cnt  <= '0;
        ready_out <= 1'b1;
        busy_out  <= 1'b0;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk_in),
    .rst_n(rst_n_in),
    .data (next_byte),
    .start(start),
    .done (done),
    .tx   (tx_out)
  );

endmodule

`default_nettype wire
